serial_subtractor: RTL

Bit-serial two's-complement subtractor for the arithmetic unit: computes `a - b` one bit per clock, LSB first. It uses a single registered borrow and a `half_subtractor` bit-cell, so it is the inverse-direction companion to the existing adder cells. A start/busy/done handshake lets a controller or bench launch an operation and collect the difference and the final borrow.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/half_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
//   sub_state_t       : controller states (IDLE, SHIFT, DONE)
//   SUB_DEFAULT_WIDTH : default operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor bit-cell.
//   x : minuend bit
//   y : subtrahend bit
//   d : difference, x ^ y
//   b : borrow, ~x & y
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, a - b, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : launch request, sampled only in IDLE
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high in SHIFT and DONE
//   done       : one-cycle completion pulse
//   diff       : (a - b) mod 2^WIDTH, updated only at completion
//   borrow_out : 1 iff a < b unsigned
//   ovf        : signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res;     // bits already produced; the final bit is d itself
  logic [CW-1:0]    cnt;
  logic             br;

  logic d1, b1, d, b2, br_nxt;
  logic [WIDTH-1:0] res_full;
  logic             last_bit;

  // full subtract = two half subtractors, borrows ORed
  half_subtractor u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .b(b1));
  half_subtractor u_hs1 (.x(d1),    .y(br),    .d(d),  .b(b2));
  assign br_nxt = b1 | b2;

  // new bit enters from the MSB side; the concatenation is the full result on
  // the last bit and drops the LSB-most stale bit otherwise
  assign res_full = {d, res};
  assign last_bit = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          sa  <= a;
          sb  <= b;
          cnt <= '0;
          br  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
`endif
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          res <= res_full[WIDTH-1:1];
          if (!last_bit) cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff       <= res_full;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // d is the result MSB on the last bit
            ovf <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
